// File: rtl/nearest_hit_scheduler_pkg.sv
// Shared definitions for the nearest-hit scheduler slice.
//  - fixed      : signed 16.16 fixed-point scalar
//  - point/ray/triangle : geometry carried between scene RAM, the scheduler
//                 and intersectionModule
//  - CODE_HIT   : intersectionModule result code meaning "ray hits triangle"
//  - nhs_state_t: scheduler FSM states
//  - hit_record : best-hit bookkeeping (valid flag, triangle index, distance)
//  - is_valid_hit: a result counts only if it is a hit in front of the origin
package nearest_hit_scheduler_pkg;

    localparam int FIXED_W    = 32;
    localparam int FIXED_FRAC = 16;
    // Widest triangle index a hit_record can hold; IDX_W must not exceed it.
    localparam int HIT_IDX_W  = 16;

    localparam logic [1:0] CODE_HIT = 2'b01;

    typedef logic signed [FIXED_W-1:0] fixed;

    typedef struct packed {
        fixed x;
        fixed y;
        fixed z;
    } point;

    typedef struct packed {
        point origin;
        point dir;
    } ray;

    typedef struct packed {
        point v1;
        point v2;
        point v3;
    } triangle;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } nhs_state_t;

    typedef struct packed {
        logic                 valid;
        logic [HIT_IDX_W-1:0] index;
        fixed                 t;
    } hit_record;

    function automatic logic is_valid_hit(input logic [1:0] code, input fixed t);
        return (code == CODE_HIT) && (t > fixed'(0));
    endfunction

endpackage

// File: rtl/nearest_hit_scheduler_hit_tracker.sv
// Nearest-hit tracker.
// Holds the best hit seen so far in a scan and folds in one intersection
// result per update pulse.
// Ports:
//  clock, reset  : system clock, synchronous active-low reset
//  clear         : drop the current best (new scan starting)
//  update        : one intersection result is presented this cycle
//  code, t       : intersectionModule result code and distance
//  index         : triangle index the result belongs to
//  best          : current best hit record
module nearest_hit_scheduler_hit_tracker
    import nearest_hit_scheduler_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             update,
    input  logic [1:0]       code,
    input  fixed             t,
    input  logic [IDX_W-1:0] index,
    output hit_record        best
);

    logic take;

    // Strictly-less replacement: triangles are scanned in ascending index
    // order, so an equal distance keeps the earlier (lower) index.
    always_comb begin
        take = 1'b0;
        if (update && is_valid_hit(code, t)) begin
            take = !best.valid || (t < best.t);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            best <= '0;
        end else if (clear) begin
            best <= '0;
        end else if (take) begin
            best.valid <= 1'b1;
            best.index <= HIT_IDX_W'(index);
            best.t     <= t;
        end
    end

endmodule

// File: rtl/nearest_hit_scheduler.sv
// Nearest-hit scheduler: initiator side of the intersectionModule
// start/ready handshake. For each triangle in scene RAM it fetches the
// vertices, clears and launches intersectionModule, waits for its result and
// keeps the nearest valid hit. Reports index and distance when the list has
// been scanned, or flags a timeout if intersectionModule stops answering.
// Ports:
//  clock, reset        : system clock, synchronous active-low reset
//  start, r, numTrigs  : scan request (accepted in IDLE/DONE only)
//  trigRdEn, trigAddr, trigData : scene RAM read port (1-cycle latency)
//  intReset, intStart, intRay, intV1..3 : drive to intersectionModule
//  intReady, intCode, intT             : result from intersectionModule
//  busy, ready, hit, hitIndex, hitT, timeoutErr : scan status and result
module nearest_hit_scheduler
    import nearest_hit_scheduler_pkg::*;
#(
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  ray               r,
    input  logic [IDX_W:0]   numTrigs,
    output logic             trigRdEn,
    output logic [IDX_W-1:0] trigAddr,
    input  triangle          trigData,
    output logic             intReset,
    output logic             intStart,
    output ray               intRay,
    output point             intV1,
    output point             intV2,
    output point             intV3,
    input  logic             intReady,
    input  logic [1:0]       intCode,
    input  fixed             intT,
    output logic             busy,
    output logic             ready,
    output logic             hit,
    output logic [IDX_W-1:0] hitIndex,
    output fixed             hitT,
    output logic             timeoutErr
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    // wait_cnt counts completed WAIT cycles, so the TIMEOUT-th WAIT cycle
    // is the one where it reads TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   MAX_TRIGS = {1'b1, {IDX_W{1'b0}}};

    nhs_state_t       state, state_nx;
    logic [IDX_W:0]   idx;
    logic [IDX_W:0]   last_idx;
    logic [IDX_W:0]   num_clamped;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             wait_expired;
    logic             result_vld;
    hit_record        best;
    logic             unused_idx_bits;

    assign num_clamped  = (numTrigs > MAX_TRIGS) ? MAX_TRIGS : numTrigs;
    assign wait_expired = (state == S_WAIT) && !intReady && (wait_cnt == CNT_LAST);
    assign result_vld   = (state == S_WAIT) && intReady;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (numTrigs == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:  state_nx = S_LOAD;
            S_LOAD:   state_nx = S_CLEAR;
            S_CLEAR:  state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (intReady) begin
                    state_nx = S_COMPARE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nx = S_DONE;
                end
            end
            S_COMPARE: state_nx = (idx == last_idx) ? S_DONE : S_FETCH;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Strobes are gated with reset so a reset landing on LAUNCH/CLEAR/FETCH
    // never leaks a pulse to the RAM or intersectionModule.
    always_comb begin
        trigRdEn = reset && (state == S_FETCH);
        intReset = reset && (state == S_CLEAR);
        intStart = reset && (state == S_LAUNCH);
        busy     = (state != S_IDLE) && (state != S_DONE);
        ready    = (state == S_DONE);
    end

    assign trigAddr = idx[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            last_idx   <= '0;
            wait_cnt   <= '0;
            timeoutErr <= 1'b0;
            intRay     <= '0;
            intV1      <= '0;
            intV2      <= '0;
            intV3      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx        <= '0;
                timeoutErr <= 1'b0;
                intRay     <= r;
                last_idx   <= num_clamped - 1'b1;
            end
            if (state == S_LOAD) begin
                intV1 <= trigData.v1;
                intV2 <= trigData.v2;
                intV3 <= trigData.v3;
            end
            if (state == S_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_expired) begin
                timeoutErr <= 1'b1;
            end
            if ((state == S_COMPARE) && (idx != last_idx)) begin
                idx <= idx + 1'b1;
            end
        end
    end

    nearest_hit_scheduler_hit_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .update (result_vld),
        .code   (intCode),
        .t      (intT),
        .index  (idx[IDX_W-1:0]),
        .best   (best)
    );

    assign hit      = best.valid;
    assign hitIndex = best.index[IDX_W-1:0];
    assign hitT     = best.t;

    // Index bits above IDX_W are always zero; reduced here so every bit of
    // the record is consumed.
    assign unused_idx_bits = ^best.index;

endmodule
